memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 67 ++++++
 tb/tb_memory_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin icache/dcache arbiter onto one RAM port, with timeout and sticky error
module memory_arbiter #(
  parameter int TIMEOUT = 64,
  parameter logic [31:0] ERRDATA = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;
  state_t r_state;
  logic r_last_d, r_err;
  logic [CW-1:0] r_cnt;
  logic w_dsrv, w_isrv, w_srv, w_dreq, w_req, w_abort, w_fail, w_done;
  logic [31:0] w_data;
  assign w_dsrv = r_state == DSERV;
  assign w_isrv = r_state == ISERV;
  assign w_srv = w_dsrv | w_isrv;
  assign w_dreq = dREN | dWEN;
  assign w_req = w_dsrv ? w_dreq : iREN;
  assign w_abort = w_srv & ~w_req;
  assign w_fail = w_srv & w_req & (ramstate != 2'b10) & ((ramstate == 2'b11) | (r_cnt == CW'(TIMEOUT - 1)));
  assign w_done = w_srv & w_req & ((ramstate == 2'b10) | w_fail);
  assign w_data = w_fail ? ERRDATA : (w_dsrv & dWEN) ? '0 : ramload;
  assign ramREN = (w_dsrv & dREN & ~dWEN) | (w_isrv & iREN);
  assign ramWEN = w_dsrv & dWEN;
  assign ramaddr = w_dsrv ? daddr : w_isrv ? iaddr : '0;
  assign ramstore = w_dsrv ? dstore : '0;
  assign dwait = ~(w_dsrv & w_done);
  assign dload = (w_dsrv & w_done) ? w_data : '0;
  assign iwait = ~(w_isrv & w_done);
  assign iload = (w_isrv & w_done) ? w_data : '0;
  assign err = r_err;
  // grant in IDLE (round-robin on contention), then serve until completion, abort or timeout
  always_ff @(posedge CLK)
    if (!nRST) begin
      r_state <= IDLE;
      r_last_d <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      if (w_dreq & (~iREN | ~r_last_d)) r_state <= DSERV;
      else if (iREN) r_state <= ISERV;
    end else if (w_done | w_abort) begin
      r_state <= IDLE;
      if (w_done) r_last_d <= w_dsrv;
      if (w_fail) r_err <= 1'b1;
    end else r_cnt <= r_cnt + 1'b1;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized scoreboard bench with directed corner cases for memory_arbiter
module tb_memory_arbiter;
  localparam logic [31:0] ERRD = 32'hBAD1BAD1;
  logic CLK = 0;
  logic nRST = 0;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = 0;
  logic iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int total = 0, bad = 0;
  logic exp_err = 0;
  logic [32:0] exp_d[$], exp_i[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  int lat = -1, fixed_lat = -1;

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] refrd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 32'h0;
  endfunction

  // RAM model: 0x1xxxxxxx hangs BUSY, 0x2xxxxxxx ends in ERROR, others ACCESS after a latency
  always @(posedge CLK) begin
    #2;
    if (ramREN === 1'b1 || ramWEN === 1'b1) begin
      if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      if (ramaddr[31:28] == 4'h1 || lat > 0) begin
        ramstate = 2'b01;
        ramload = $urandom;
        if (lat > 0) lat--;
      end else begin
        ramstate = (ramaddr[31:28] == 4'h2) ? 2'b11 : 2'b10;
        ramload = ramREN ? (mem.exists(ramaddr) ? mem[ramaddr] : 32'h0) : $urandom;
        if (ramWEN && ramstate == 2'b10) mem[ramaddr] = ramstore;
        lat = -1;
      end
    end else begin
      lat = -1;
      ramstate = 2'b00;
      ramload = $urandom;
    end
  end

  // scoreboard monitor: every completion must match the oldest expectation of that side
  always @(negedge CLK) begin
    logic [32:0] e;
    logic nerr;
    if (nRST) begin
      nerr = exp_err;
      chk("err", 32'(err), 32'(exp_err));
      chk("single_done", 32'(!dwait && !iwait), 32'h0);
      if (ramWEN) begin
        chk("ramaddr_w", ramaddr, daddr);
        chk("ramstore_w", ramstore, dstore);
      end
      if (dwait) chk("dload_idle", dload, 32'h0);
      else if (exp_d.size() == 0) begin
        total++; bad++;
        $display("FAIL d_spurious: dwait=0 with dload %h, none expected", dload);
      end else begin
        e = exp_d.pop_front();
        chk("dload", dload, e[31:0]);
        if (e[32]) nerr = 1'b1;
      end
      if (iwait) chk("iload_idle", iload, 32'h0);
      else if (exp_i.size() == 0) begin
        total++; bad++;
        $display("FAIL i_spurious: iwait=0 with iload %h, none expected", iload);
      end else begin
        e = exp_i.pop_front();
        chk("iload", iload, e[31:0]);
        if (e[32]) nerr = 1'b1;
      end
      exp_err = nerr;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    exp_err = 0;
    exp_d.delete();
    exp_i.delete();
    tick();
    nRST = 1;
  endtask

  task automatic wait_done(input bit is_d, output int n);
    for (n = 1; n <= 400; n++) begin
      @(negedge CLK);
      if ((is_d ? dwait : iwait) == 1'b0) return;
    end
    total++; bad++;
    $display("FAIL %s_timeout: got no completion want one within 400 cycles", is_d ? "d" : "i");
  endtask

  task automatic d_txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] v, output int n);
    logic [32:0] e;
    e = (a[31:28] != 4'h0) ? {1'b1, ERRD} : {1'b0, wr ? 32'h0 : refrd(a)};
    if (wr && a[31:28] == 4'h0) refm[a] = v;
    exp_d.push_back(e);
    daddr = a; dstore = v; dWEN = wr; dREN = rd;
    wait_done(1, n);
    tick();
    dREN = 0; dWEN = 0;
  endtask

  task automatic i_txn(input logic [31:0] a, output int n);
    exp_i.push_back((a[31:28] != 4'h0) ? {1'b1, ERRD} : {1'b0, refrd(a)});
    iaddr = a; iREN = 1;
    wait_done(0, n);
    tick();
    iREN = 0;
  endtask

  task automatic d_master();
    for (int k = 0; k < 30; k++) begin
      int r, n;
      logic [31:0] a;
      repeat ($urandom_range(0, 3)) tick();
      r = $urandom_range(0, 19);
      if (r == 0) d_txn(0, 1, 32'h1000_0000 | 32'($urandom_range(0, 7)), 0, n);
      else if (r <= 2) d_txn(1'($urandom_range(0, 1)), 1, 32'h2000_0000 | 32'($urandom_range(0, 63)), $urandom, n);
      else if (r <= 10) d_txn(1, 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 31)), $urandom, n);
      else begin
        a = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : 32'h100 + 32'($urandom_range(0, 31));
        d_txn(0, 1, a, $urandom, n);
      end
    end
  endtask

  task automatic i_master();
    for (int k = 0; k < 30; k++) begin
      int n;
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 9) == 0) i_txn(32'h2000_0000 | 32'($urandom_range(0, 63)), n);
      else i_txn(32'($urandom_range(0, 64)), n);
    end
  endtask

  initial begin
    int n;
    int seq[$];
    logic [31:0] v;
    for (int a = 0; a < 64; a++) begin
      v = $urandom;
      mem[32'(a)] = v;
      refm[32'(a)] = v;
    end
    mem[32'h40] = 32'h1234;
    refm[32'h40] = 32'h1234;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 32'h1);
    chk("rst_dwait", 32'(dwait), 32'h1);
    chk("rst_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // icache read with three BUSY cycles
    fixed_lat = 3;
    tick();
    iREN = 1; iaddr = 32'h40;
    exp_i.push_back({1'b0, 32'h1234});
    @(negedge CLK);
    chk("i_lat_ramREN", 32'(ramREN), 32'h0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 6) iREN = 0;
      @(negedge CLK);
      chk($sformatf("i_c%0d_iwait", c), 32'(iwait), (c == 5) ? 32'h0 : 32'h1);
      chk($sformatf("i_c%0d_ramREN", c), 32'(ramREN), (c < 6) ? 32'h1 : 32'h0);
      if (c < 6) chk("i_ramaddr", ramaddr, 32'h40);
    end

    // dcache write with immediate ACCESS
    fixed_lat = 0;
    tick();
    dWEN = 1; daddr = 32'h80; dstore = 32'hCAFE;
    refm[32'h80] = 32'hCAFE;
    exp_d.push_back({1'b0, 32'h0});
    @(negedge CLK);
    chk("w_lat_ramWEN", 32'(ramWEN), 32'h0);
    tick();
    @(negedge CLK);
    chk("w_ramWEN", 32'(ramWEN), 32'h1);
    chk("w_ramstore", ramstore, 32'hCAFE);
    chk("w_dwait", 32'(dwait), 32'h0);
    tick();
    dWEN = 0;
    @(negedge CLK);
    chk("w_after_dwait", 32'(dwait), 32'h1);
    chk("w_after_ramWEN", 32'(ramWEN), 32'h0);
    fixed_lat = -1;
    tick();
    d_txn(0, 1, 32'h80, 0, n);

    // contention held from reset alternates D, I, D
    do_reset();
    fixed_lat = 1;
    dREN = 1; daddr = 32'h20; iREN = 1; iaddr = 32'h10;
    exp_d.push_back({1'b0, refrd(32'h20)});
    exp_d.push_back({1'b0, refrd(32'h20)});
    exp_i.push_back({1'b0, refrd(32'h10)});
    for (int c = 0; c < 30 && seq.size() < 3; c++) begin
      @(negedge CLK);
      if (!dwait) seq.push_back(1);
      if (!iwait) seq.push_back(2);
    end
    tick();
    dREN = 0; iREN = 0;
    chk("rr_count", 32'(seq.size()), 32'd3);
    for (int k = 0; k < 3 && k < seq.size(); k++) chk($sformatf("rr_order%0d", k), 32'(seq[k]), (k == 1) ? 32'd2 : 32'd1);

    // dcache abort mid-service hands the port to the waiting icache
    do_reset();
    fixed_lat = 5;
    dREN = 1; daddr = 32'h20; iREN = 1; iaddr = 32'h11;
    exp_i.push_back({1'b0, refrd(32'h11)});
    tick();
    @(negedge CLK);
    chk("ab_d_ramREN", 32'(ramREN), 32'h1);
    chk("ab_d_ramaddr", ramaddr, 32'h20);
    tick();
    dREN = 0;
    @(negedge CLK);
    chk("ab_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
    chk("ab_dwait", 32'(dwait), 32'h1);
    tick();
    @(negedge CLK);
    chk("ab_idle_ramREN", 32'(ramREN), 32'h0);
    tick();
    @(negedge CLK);
    chk("ab_i_ramREN", 32'(ramREN), 32'h1);
    chk("ab_i_ramaddr", ramaddr, 32'h11);
    wait_done(0, n);
    tick();
    iREN = 0;
    fixed_lat = -1;

    // hung RAM forces a timeout error after 64 service cycles
    do_reset();
    d_txn(0, 1, 32'h1000_0000, 0, n);
    chk("to_cycles", 32'(n), 32'd65);
    repeat (3) tick();
    @(negedge CLK);
    chk("to_err", 32'(err), 32'h1);
    tick();
    d_txn(0, 1, 32'h05, 0, n);
    @(negedge CLK);
    chk("to_err_sticky", 32'(err), 32'h1);

    // reset in the middle of an icache service drops it silently
    fixed_lat = 20;
    tick();
    iREN = 1; iaddr = 32'h12;
    repeat (2) tick();
    @(negedge CLK);
    chk("rs_ramREN_before", 32'(ramREN), 32'h1);
    tick();
    nRST = 0;
    exp_err = 0;
    exp_i.delete();
    @(posedge CLK);
    @(negedge CLK);
    chk("rs_iwait", 32'(iwait), 32'h1);
    chk("rs_ramREN", 32'(ramREN), 32'h0);
    chk("rs_ramaddr", ramaddr, 32'h0);
    chk("rs_err", 32'(err), 32'h0);
    tick();
    nRST = 1; iREN = 0;
    repeat (5) tick();
    fixed_lat = -1;

    // randomized concurrent traffic from both caches
    do_reset();
    fork
      d_master();
      i_master();
    join
    repeat (4) tick();
    chk("d_queue_empty", 32'(exp_d.size()), 32'h0);
    chk("i_queue_empty", 32'(exp_i.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
